// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter datapath:
// state encoding, direction codes and default sizes.
package shifter_pkg;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-position logical shifter, zero fill,
// direction chosen by dir_i.
module shift_step
  import shifter_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] data_i,
  input  logic         dir_i,
  output logic [W-1:0] data_o
);

  assign data_o = (dir_i == DIR_RIGHT)
                ? {1'b0, data_i[W-1:1]}
                : {data_i[W-2:0], 1'b0};

endmodule

// File: rtl/seq_shifter.sv
// Sequential bit-serial shifter: one position per
// clock, start/done handshake, result held in out.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH,
  parameter int SHW   = shifter_pkg::SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_e           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;

  shift_step #(
    .W (WIDTH)
  ) u_step (
    .data_i (data_q),
    .dir_i  (dir_q),
    .data_o (data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= DIR_LEFT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            data_q  <= in;
            cnt_q   <= shamt;
            dir_q   <= dir;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            data_q <= data_d;
            cnt_q  <= cnt_q - SHW'(1);
          end else begin
            out_q   <= data_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
